// File: rtl/axil_pkg.sv
// ============================================================================
// Module  : axil_pkg
// Purpose : Shared arbiter state encoding and AXI-lite response codes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package axil_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axil_arbiter_2x1_if.sv
// ============================================================================
// Module  : axil_if
// Purpose : AXI-lite channel bundle with master/slave views.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface axil_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

`default_nettype wire

// File: rtl/axil_arb_sel.sv
// ============================================================================
// Module  : axil_arb_sel
// Purpose : Two-input grant selector; round-robin when AXIL_ARB_RR_EN is
//           defined, fixed priority (requester 0 first) otherwise.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_arb_sel (
    input  wire logic [1:0] i_req,
    input  wire logic       i_last_grant,
    output logic            o_grant,
    output logic            o_valid
);

    assign o_valid = |i_req;

`ifdef AXIL_ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    always_comb begin
        o_grant = i_req[1];
        if (i_req == 2'b11) begin
            o_grant = ~i_last_grant;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
    assign o_grant             = i_req[1] & ~i_req[0];
`endif

endmodule

`default_nettype wire

// File: rtl/axil_arbiter_2x1.sv
// ============================================================================
// Module  : axil_arbiter_2x1
// Purpose : Two-requester AXI-lite arbiter, one transaction in flight.
//           AXIL_ARB_RR_EN selects round-robin instead of fixed priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_arbiter_2x1
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    axil_if.slave     s0_axil,
    axil_if.slave     s1_axil,
    axil_if.master    m_axil
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_grant;
    logic       r_aw_done;
    logic       r_w_done;
    logic       r_ar_done;
    logic       w_last_grant;
    logic       w_sel;
    logic       w_any_req;
    logic       w_sel_awvalid;
    logic [1:0] w_req;
    logic       w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    // Signals of the currently granted requester.
    logic [ADDR_WIDTH-1:0] w_g_awaddr, w_g_araddr;
    logic [2:0]            w_g_awprot, w_g_arprot;
    logic [DATA_WIDTH-1:0] w_g_wdata;
    logic [STRB_WIDTH-1:0] w_g_wstrb;
    logic                  w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;

    // Response-side values destined for the granted requester.
    logic                  w_up_awready, w_up_wready, w_up_bvalid, w_up_arready, w_up_rvalid;
    logic [1:0]            w_up_bresp, w_up_rresp;
    logic [DATA_WIDTH-1:0] w_up_rdata;

    assign w_req = {s1_axil.awvalid | s1_axil.arvalid, s0_axil.awvalid | s0_axil.arvalid};
    assign w_sel_awvalid = w_sel ? s1_axil.awvalid : s0_axil.awvalid;

    axil_arb_sel u_sel (
        .i_req        (w_req),
        .i_last_grant (w_last_grant),
        .o_grant      (w_sel),
        .o_valid      (w_any_req)
    );

`ifdef AXIL_ARB_RR_EN
    logic r_last_grant;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (r_state == IDLE && w_any_req) begin
            r_last_grant <= w_sel;
        end
    end
    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = 1'b1;
`endif

    assign w_g_awaddr  = r_grant ? s1_axil.awaddr  : s0_axil.awaddr;
    assign w_g_awprot  = r_grant ? s1_axil.awprot  : s0_axil.awprot;
    assign w_g_awvalid = r_grant ? s1_axil.awvalid : s0_axil.awvalid;
    assign w_g_wdata   = r_grant ? s1_axil.wdata   : s0_axil.wdata;
    assign w_g_wstrb   = r_grant ? s1_axil.wstrb   : s0_axil.wstrb;
    assign w_g_wvalid  = r_grant ? s1_axil.wvalid  : s0_axil.wvalid;
    assign w_g_bready  = r_grant ? s1_axil.bready  : s0_axil.bready;
    assign w_g_araddr  = r_grant ? s1_axil.araddr  : s0_axil.araddr;
    assign w_g_arprot  = r_grant ? s1_axil.arprot  : s0_axil.arprot;
    assign w_g_arvalid = r_grant ? s1_axil.arvalid : s0_axil.arvalid;
    assign w_g_rready  = r_grant ? s1_axil.rready  : s0_axil.rready;

    assign w_aw_hs = m_axil.awvalid & m_axil.awready;
    assign w_w_hs  = m_axil.wvalid  & m_axil.wready;
    assign w_b_hs  = m_axil.bvalid  & m_axil.bready;
    assign w_ar_hs = m_axil.arvalid & m_axil.arready;
    assign w_r_hs  = m_axil.rvalid  & m_axil.rready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_aw_done <= (r_aw_done | w_aw_hs) & ~w_b_hs;
            r_w_done  <= (r_w_done  | w_w_hs)  & ~w_b_hs;
            r_ar_done <= (r_ar_done | w_ar_hs) & ~w_r_hs;
            if (r_state == IDLE && w_any_req) begin
                r_grant <= w_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        m_axil.awaddr  = '0;
        m_axil.awprot  = '0;
        m_axil.awvalid = 1'b0;
        m_axil.wdata   = '0;
        m_axil.wstrb   = '0;
        m_axil.wvalid  = 1'b0;
        m_axil.bready  = 1'b0;
        m_axil.araddr  = '0;
        m_axil.arprot  = '0;
        m_axil.arvalid = 1'b0;
        m_axil.rready  = 1'b0;
        w_up_awready   = 1'b0;
        w_up_wready    = 1'b0;
        w_up_bvalid    = 1'b0;
        w_up_bresp     = '0;
        w_up_arready   = 1'b0;
        w_up_rvalid    = 1'b0;
        w_up_rdata     = '0;
        w_up_rresp     = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_sel_awvalid ? WRITE : READ;
                end
            end
            WRITE: begin
                m_axil.awaddr  = w_g_awaddr;
                m_axil.awprot  = w_g_awprot;
                m_axil.awvalid = w_g_awvalid & ~r_aw_done;
                w_up_awready   = m_axil.awready & ~r_aw_done;
                m_axil.wdata   = w_g_wdata;
                m_axil.wstrb   = w_g_wstrb;
                m_axil.wvalid  = w_g_wvalid & ~r_w_done;
                w_up_wready    = m_axil.wready & ~r_w_done;
                // B is only exposed once both address and data have been accepted.
                if (r_aw_done && r_w_done) begin
                    m_axil.bready = w_g_bready;
                    w_up_bvalid   = m_axil.bvalid;
                    w_up_bresp    = m_axil.bresp;
                    if (m_axil.bvalid && w_g_bready) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                m_axil.araddr  = w_g_araddr;
                m_axil.arprot  = w_g_arprot;
                m_axil.arvalid = w_g_arvalid & ~r_ar_done;
                w_up_arready   = m_axil.arready & ~r_ar_done;
                if (r_ar_done) begin
                    m_axil.rready = w_g_rready;
                    w_up_rvalid   = m_axil.rvalid;
                    w_up_rdata    = m_axil.rdata;
                    w_up_rresp    = m_axil.rresp;
                    if (m_axil.rvalid && w_g_rready) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // w_up_* are all zero in IDLE, so routing only needs the grant bit.
    assign s0_axil.awready = ~r_grant & w_up_awready;
    assign s0_axil.wready  = ~r_grant & w_up_wready;
    assign s0_axil.bvalid  = ~r_grant & w_up_bvalid;
    assign s0_axil.bresp   = r_grant ? 2'b00 : w_up_bresp;
    assign s0_axil.arready = ~r_grant & w_up_arready;
    assign s0_axil.rvalid  = ~r_grant & w_up_rvalid;
    assign s0_axil.rdata   = r_grant ? '0 : w_up_rdata;
    assign s0_axil.rresp   = r_grant ? 2'b00 : w_up_rresp;

    assign s1_axil.awready = r_grant & w_up_awready;
    assign s1_axil.wready  = r_grant & w_up_wready;
    assign s1_axil.bvalid  = r_grant & w_up_bvalid;
    assign s1_axil.bresp   = r_grant ? w_up_bresp : 2'b00;
    assign s1_axil.arready = r_grant & w_up_arready;
    assign s1_axil.rvalid  = r_grant & w_up_rvalid;
    assign s1_axil.rdata   = r_grant ? w_up_rdata : '0;
    assign s1_axil.rresp   = r_grant ? w_up_rresp : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_axil_arbiter_2x1.sv
// ============================================================================
// Module  : tb_axil_arbiter_2x1
// Purpose : Directed self-checking bench for axil_arbiter_2x1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axil_arbiter_2x1;

    logic clk;
    logic rst;

    axil_if s0_if ();
    axil_if s1_if ();
    axil_if m_if ();

    axil_arbiter_2x1 dut (
        .clk     (clk),
        .rst     (rst),
        .s0_axil (s0_if),
        .s1_axil (s1_if),
        .m_axil  (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester-side stimulus state
    logic [1:0]  aw_req = '0, w_req = '0, ar_req = '0, keep_req = '0;
    logic [23:0] awaddr_v [2];
    logic [23:0] araddr_v [2];
    logic [31:0] wdata_v  [2];
    logic [3:0]  wstrb_v  [2];
    int          b_cnt [2];
    int          r_cnt [2];
    logic [1:0]  bresp_last [2];
    logic [31:0] rdata_last [2];
    logic        s0_leak = 1'b0, s1_leak = 1'b0;
    int          gq[$];

    assign s0_if.awvalid = aw_req[0];
    assign s0_if.awaddr  = awaddr_v[0];
    assign s0_if.awprot  = 3'd0;
    assign s0_if.wvalid  = w_req[0];
    assign s0_if.wdata   = wdata_v[0];
    assign s0_if.wstrb   = wstrb_v[0];
    assign s0_if.bready  = 1'b1;
    assign s0_if.arvalid = ar_req[0];
    assign s0_if.araddr  = araddr_v[0];
    assign s0_if.arprot  = 3'd0;
    assign s0_if.rready  = 1'b1;

    assign s1_if.awvalid = aw_req[1];
    assign s1_if.awaddr  = awaddr_v[1];
    assign s1_if.awprot  = 3'd0;
    assign s1_if.wvalid  = w_req[1];
    assign s1_if.wdata   = wdata_v[1];
    assign s1_if.wstrb   = wstrb_v[1];
    assign s1_if.bready  = 1'b1;
    assign s1_if.arvalid = ar_req[1];
    assign s1_if.araddr  = araddr_v[1];
    assign s1_if.arprot  = 3'd0;
    assign s1_if.rready  = 1'b1;

    // Downstream slave model state
    logic        sl_aw = 1'b0, sl_w = 1'b0, b_armed = 1'b0, r_armed = 1'b0;
    logic        bvalid_r = 1'b0, rvalid_r = 1'b0;
    int          b_wait = 0, r_wait = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  sl_bresp = 2'b00;
    logic [31:0] sl_rdata = '0;
    logic [23:0] sl_awaddr = '0;
    logic [31:0] sl_wdata = '0;
    logic [3:0]  sl_wstrb = '0;

    assign m_if.awready = 1'b1;
    assign m_if.wready  = 1'b1;
    assign m_if.arready = 1'b1;
    assign m_if.bvalid  = bvalid_r;
    assign m_if.bresp   = sl_bresp;
    assign m_if.rvalid  = rvalid_r;
    assign m_if.rdata   = sl_rdata;
    assign m_if.rresp   = 2'b00;

    // Handshakes sampled mid-cycle, applied just after the next rising edge.
    logic [1:0]  hs_aw, hs_w, hs_ar, hs_b, hs_r;
    logic [1:0]  cap_bresp [2];
    logic [31:0] cap_rdata [2];
    logic        lk0, lk1, mh_aw, mh_w, mh_ar, mh_b, mh_r;
    logic [23:0] cap_awaddr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    initial begin
        for (int i = 0; i < 2; i++) begin
            awaddr_v[i] = '0; araddr_v[i] = '0; wdata_v[i] = '0; wstrb_v[i] = '0;
            b_cnt[i] = 0; r_cnt[i] = 0; bresp_last[i] = '0; rdata_last[i] = '0;
        end
        forever begin
            @(negedge clk);
            hs_aw = {s1_if.awvalid & s1_if.awready, s0_if.awvalid & s0_if.awready};
            hs_w  = {s1_if.wvalid  & s1_if.wready,  s0_if.wvalid  & s0_if.wready};
            hs_ar = {s1_if.arvalid & s1_if.arready, s0_if.arvalid & s0_if.arready};
            hs_b  = {s1_if.bvalid  & s1_if.bready,  s0_if.bvalid  & s0_if.bready};
            hs_r  = {s1_if.rvalid  & s1_if.rready,  s0_if.rvalid  & s0_if.rready};
            cap_bresp[0] = s0_if.bresp; cap_bresp[1] = s1_if.bresp;
            cap_rdata[0] = s0_if.rdata; cap_rdata[1] = s1_if.rdata;
            lk0 = s0_if.awready | s0_if.wready | s0_if.bvalid | s0_if.arready | s0_if.rvalid
                | (s0_if.rdata != 0) | (s0_if.bresp != 0) | (s0_if.rresp != 0);
            lk1 = s1_if.awready | s1_if.wready | s1_if.bvalid | s1_if.arready | s1_if.rvalid
                | (s1_if.rdata != 0) | (s1_if.bresp != 0) | (s1_if.rresp != 0);
            mh_aw = m_if.awvalid & m_if.awready;
            mh_w  = m_if.wvalid  & m_if.wready;
            mh_ar = m_if.arvalid & m_if.arready;
            mh_b  = m_if.bvalid  & m_if.bready;
            mh_r  = m_if.rvalid  & m_if.rready;
            cap_awaddr = m_if.awaddr;
            cap_wdata  = m_if.wdata;
            cap_wstrb  = m_if.wstrb;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hs_aw[i]) begin aw_req[i] = 1'b0; gq.push_back(i * 2); end
                if (hs_w[i])  w_req[i] = 1'b0;
                if (hs_ar[i]) begin ar_req[i] = 1'b0; gq.push_back(i * 2 + 1); end
                if (hs_b[i])  begin b_cnt[i]++; bresp_last[i] = cap_bresp[i]; end
                if (hs_r[i])  begin
                    r_cnt[i]++;
                    rdata_last[i] = cap_rdata[i];
                    if (keep_req[i]) ar_req[i] = 1'b1;
                end
            end
            if (lk0) s0_leak = 1'b1;
            if (lk1) s1_leak = 1'b1;
            if (!rst) begin
                sl_aw = 1'b0; sl_w = 1'b0; b_armed = 1'b0; bvalid_r = 1'b0;
                r_armed = 1'b0; rvalid_r = 1'b0;
            end else begin
                if (mh_aw) begin sl_aw = 1'b1; sl_awaddr = cap_awaddr; end
                if (mh_w)  begin sl_w = 1'b1; sl_wdata = cap_wdata; sl_wstrb = cap_wstrb; end
                if (mh_b)  begin bvalid_r = 1'b0; sl_aw = 1'b0; sl_w = 1'b0; end
                if (sl_aw && sl_w && !bvalid_r && !b_armed) begin b_armed = 1'b1; b_wait = b_delay; end
                if (b_armed) begin
                    if (b_wait == 0) begin bvalid_r = 1'b1; b_armed = 1'b0; end
                    else b_wait--;
                end
                if (mh_r)  rvalid_r = 1'b0;
                if (mh_ar) begin r_armed = 1'b1; r_wait = r_delay; end
                if (r_armed) begin
                    if (r_wait == 0) begin rvalid_r = 1'b1; r_armed = 1'b0; end
                    else r_wait--;
                end
            end
        end
    end

    function automatic int gq_at(input int k);
        return (k < gq.size()) ? gq[k] : -1;
    endfunction

    task automatic wait_quiet(input string tag);
        int n = 0;
        while (n < 300 && !((aw_req | w_req | ar_req) == 0 && !sl_aw && !sl_w && !b_armed
                            && !bvalid_r && !r_armed && !rvalid_r)) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 300, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_g [4];
        int bad;
        int r0_save, b1_save, r1_save;

        // ---- reset ----
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_awvalid", m_if.awvalid, 1'b0);
        check("rst_m_arvalid", m_if.arvalid, 1'b0);
        check("rst_s0_awready", s0_if.awready, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_m_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, 5'd0);

        // ---- simultaneous reads, requesters keep requesting ----
        sl_rdata = 32'hA5A50000;
        @(posedge clk); #2;
        gq.delete();
        araddr_v[0] = 24'h000100; araddr_v[1] = 24'h000200;
        keep_req = 2'b11;
        ar_req   = 2'b11;
        bad = 0;
        while (gq.size() < 4 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        keep_req = 2'b00;
        check("tie_grants_seen", gq.size() >= 4, 1'b1);
`ifdef AXIL_ARB_RR_EN
        exp_g = '{1, 3, 1, 3};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        for (int k = 0; k < 4; k++) check($sformatf("tie_grant%0d", k), gq_at(k), exp_g[k]);
        wait_quiet("tie_drain");

        // ---- single write from s0, W one cycle after AW ----
        @(posedge clk); #2;
        gq.delete();
        s1_leak = 1'b0;
        awaddr_v[0] = 24'h010004;
        aw_req[0]   = 1'b1;
        @(negedge clk);
        check("arb_latency_pre", m_if.awvalid, 1'b0);
        @(posedge clk); #2;
        wdata_v[0] = 32'hDEADBEEF;
        wstrb_v[0] = 4'hF;
        w_req[0]   = 1'b1;
        @(negedge clk);
        check("wr_m_awvalid", m_if.awvalid, 1'b1);
        check("wr_m_awaddr", m_if.awaddr, 24'h010004);
        check("wr_m_wvalid", m_if.wvalid, 1'b1);
        check("wr_m_wdata", m_if.wdata, 32'hDEADBEEF);
        check("wr_m_wstrb", m_if.wstrb, 4'hF);
        check("wr_s0_awready", s0_if.awready, 1'b1);
        wait_quiet("wr_done");
        check("wr_sl_awaddr", sl_awaddr, 24'h010004);
        check("wr_sl_wdata", sl_wdata, 32'hDEADBEEF);
        check("wr_s0_bcnt", b_cnt[0], 1);
        check("wr_s0_bresp", bresp_last[0], 2'b00);
        check("wr_s1_zero", s1_leak, 1'b0);

        // ---- s1 write+read together: write first, rdata only to s1 ----
        @(posedge clk); #2;
        gq.delete();
        s0_leak  = 1'b0;
        r1_save  = r_cnt[1];
        sl_rdata = 32'h12345678;
        awaddr_v[1] = 24'h020000; wdata_v[1] = 32'h0BADF00D; wstrb_v[1] = 4'h3;
        araddr_v[1] = 24'h020004;
        aw_req[1] = 1'b1; w_req[1] = 1'b1; ar_req[1] = 1'b1;
        wait_quiet("wr_rd_done");
        check("wr_rd_first", gq_at(0), 2);
        check("wr_rd_second", gq_at(1), 3);
        check("wr_rd_s1_rcnt", r_cnt[1], r1_save + 1);
        check("wr_rd_s1_rdata", rdata_last[1], 32'h12345678);
        check("wr_rd_s0_zero", s0_leak, 1'b0);

        // ---- slow B: grant held, s0 read stays pending, SLVERR passes through ----
        @(posedge clk); #2;
        gq.delete();
        b1_save  = b_cnt[1];
        b_delay  = 20;
        sl_bresp = 2'b10;
        awaddr_v[1] = 24'h030000; wdata_v[1] = 32'h11112222; wstrb_v[1] = 4'hF;
        aw_req[1] = 1'b1; w_req[1] = 1'b1;
        @(posedge clk); #2;
        araddr_v[0] = 24'h000300;
        ar_req[0]   = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (m_if.awvalid | m_if.wvalid | m_if.arvalid | s0_if.arready | s1_if.bvalid) bad++;
        end
        check("hold_no_valid", bad, 0);
        check("hold_s0_pending", ar_req[0], 1'b1);
        wait_quiet("hold_done");
        check("hold_order0", gq_at(0), 2);
        check("hold_order1", gq_at(1), 1);
        check("hold_s1_bcnt", b_cnt[1], b1_save + 1);
        check("hold_s1_bresp", bresp_last[1], 2'b10);
        b_delay  = 0;
        sl_bresp = 2'b00;

        // ---- reset right after an AR handshake ----
        @(posedge clk); #2;
        gq.delete();
        r0_save = r_cnt[0];
        r_delay = 3;
        araddr_v[0] = 24'h000400;
        ar_req[0]   = 1'b1;
        bad = 0;
        while (gq.size() < 1 && bad < 20) begin
            @(negedge clk);
            bad++;
        end
        check("abort_ar_seen", gq.size(), 1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_m_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, 5'd0);
        check("abort_s0_rvalid", s0_if.rvalid, 1'b0);
        @(posedge clk); #2;
        gq.delete();
        r_delay = 0;
        ar_req  = 2'b11;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("abort_first_cycle", {m_if.arvalid, s0_if.arready, s1_if.arready}, 3'd0);
        wait_quiet("abort_drain");
        check("abort_first_grant", gq_at(0), 1);
        check("abort_s0_rcnt", r_cnt[0], r0_save + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
